// File: rtl/univ_reg.sv
// univ_reg: WIDTH-bit universal register with hold, parallel load,
// shift, rotate and up/down count modes, plus a terminal-count flag
// for cascading counters. No handshake: every enabled edge applies
// exactly one operation selected by MODE.
module univ_reg #(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic [2:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             SIN_L,
  input  logic             SIN_R,
  output logic [WIDTH-1:0] Q,
  output logic             SOUT_L,
  output logic             SOUT_R,
  output logic             TC
);

  typedef enum logic [2:0] {
    M_HOLD  = 3'b000,
    M_LOAD  = 3'b001,
    M_SHL   = 3'b010,
    M_SHR   = 3'b011,
    M_ROL   = 3'b100,
    M_ROR   = 3'b101,
    M_UP    = 3'b110,
    M_DOWN  = 3'b111
  } mode_e;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_next;
  logic             all_ones;
  logic             all_zero;

  assign all_ones = &Q;
  assign all_zero = ~|Q;

  // Next value for each mode; EN=0 degenerates to hold.
  always_comb begin
    q_next = Q;
    if (EN) begin
      case (mode_e'(MODE))
        M_HOLD: q_next = Q;
        M_LOAD: q_next = D;
        M_SHL:  q_next = {Q[WIDTH-2:0], SIN_R};
        M_SHR:  q_next = {SIN_L, Q[WIDTH-1:1]};
        M_ROL:  q_next = {Q[WIDTH-2:0], Q[WIDTH-1]};
        M_ROR:  q_next = {Q[0], Q[WIDTH-1:1]};
        M_UP:   q_next = Q + ONE;
        M_DOWN: q_next = Q - ONE;
        default: q_next = Q;
      endcase
    end
  end

  // State register; reset wins over any enabled operation.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      Q <= RESET_VAL;
    end else begin
      Q <= q_next;
    end
  end

  // Serial outputs and terminal count: TC flags the cycle whose edge
  // wraps the counter, so it can drive the next stage's EN directly.
  always_comb begin
    SOUT_L = Q[WIDTH-1];
    SOUT_R = Q[0];
    TC     = EN & ~RESET &
             (((MODE == M_UP) & all_ones) | ((MODE == M_DOWN) & all_zero));
  end

endmodule

// File: tb/tb_univ_reg.sv
// tb_univ_reg: directed vector table, multi-cycle corner sequences and a
// randomized run against an arithmetic reference model.
module tb_univ_reg;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit instance, RESET_VAL = A5
  logic       rst8, en8, sl8, sr8;
  logic [2:0] mode8;
  logic [7:0] d8, q8;
  logic       soutl8, soutr8, tc8;

  univ_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) dut8 (
    .CLK(clk), .RESET(rst8), .EN(en8), .MODE(mode8), .D(d8),
    .SIN_L(sl8), .SIN_R(sr8), .Q(q8), .SOUT_L(soutl8), .SOUT_R(soutr8), .TC(tc8)
  );

  // 2-bit instance, RESET_VAL = 2'b10
  logic       rst2, en2, sl2, sr2;
  logic [2:0] mode2;
  logic [1:0] d2, q2;
  logic       soutl2, soutr2, tc2;

  univ_reg #(.WIDTH(2), .RESET_VAL(2'b10)) dut2 (
    .CLK(clk), .RESET(rst2), .EN(en2), .MODE(mode2), .D(d2),
    .SIN_L(sl2), .SIN_R(sr2), .Q(q2), .SOUT_L(soutl2), .SOUT_R(soutr2), .TC(tc2)
  );

  // Two 4-bit counters cascaded via TC -> EN
  logic       cas_rst, lo_en;
  logic [3:0] lo_q, hi_q;
  logic       lo_sl, lo_sr, hi_sl, hi_sr, lo_tc, hi_tc;

  univ_reg #(.WIDTH(4), .RESET_VAL(4'h0)) dut_lo (
    .CLK(clk), .RESET(cas_rst), .EN(lo_en), .MODE(3'b110), .D(4'h0),
    .SIN_L(1'b0), .SIN_R(1'b0), .Q(lo_q), .SOUT_L(lo_sl), .SOUT_R(lo_sr), .TC(lo_tc)
  );

  univ_reg #(.WIDTH(4), .RESET_VAL(4'h0)) dut_hi (
    .CLK(clk), .RESET(cas_rst), .EN(lo_tc), .MODE(3'b110), .D(4'h0),
    .SIN_L(1'b0), .SIN_R(1'b0), .Q(hi_q), .SOUT_L(hi_sl), .SOUT_R(hi_sr), .TC(hi_tc)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] ref_next(input logic [7:0] q, input logic rst,
                                          input logic en, input logic [2:0] mode,
                                          input logic [7:0] d, input logic sl,
                                          input logic sr);
    int v;
    v = int'(q);
    if (rst) return 8'hA5;
    if (!en) return q;
    case (mode)
      3'd0: v = v;
      3'd1: v = int'(d);
      3'd2: v = (v * 2 + int'(sr)) % 256;
      3'd3: v = v / 2 + int'(sl) * 128;
      3'd4: v = (v * 2) % 256 + v / 128;
      3'd5: v = v / 2 + (v % 2) * 128;
      3'd6: v = (v + 1) % 256;
      default: v = (v + 255) % 256;
    endcase
    return v[7:0];
  endfunction

  function automatic logic ref_tc(input logic [7:0] q, input logic rst,
                                  input logic en, input logic [2:0] mode);
    return en && !rst && ((mode == 3'd6 && q == 8'd255) || (mode == 3'd7 && q == 8'd0));
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    string      name;
    logic       rst;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sl;
    logic       sr;
    logic [7:0] eq;   // Q after the edge
    logic       etc;  // TC before the edge
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic r, input logic e, input logic [2:0] m,
                     input logic [7:0] d, input logic sl, input logic sr,
                     input logic [7:0] eq, input logic etc);
    vec_t v;
    v.name = n; v.rst = r; v.en = e; v.mode = m; v.d = d;
    v.sl = sl; v.sr = sr; v.eq = eq; v.etc = etc;
    vecs.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive8(input logic r, input logic e, input logic [2:0] m,
                        input logic [7:0] d, input logic sl, input logic sr);
    rst8 = r; en8 = e; mode8 = m; d8 = d; sl8 = sl; sr8 = sr;
  endtask

  task automatic drive2(input logic r, input logic e, input logic [2:0] m,
                        input logic [1:0] d, input logic sl, input logic sr);
    rst2 = r; en2 = e; mode2 = m; d2 = d; sl2 = sl; sr2 = sr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- test ----------------
  initial begin
    drive8(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    drive2(1'b0, 1'b0, 3'd0, 2'b00, 1'b0, 1'b0);
    cas_rst = 1'b0;
    lo_en   = 1'b0;

    // reset and hold
    add("rst",      1, 1, 3'd0, 8'h00, 0, 0, 8'hA5, 0);
    add("hold1",    0, 1, 3'd0, 8'h00, 0, 0, 8'hA5, 0);
    add("hold2",    0, 1, 3'd0, 8'h11, 1, 1, 8'hA5, 0);
    add("hold3",    0, 1, 3'd0, 8'h22, 0, 0, 8'hA5, 0);
    // load / shift
    add("load81",   0, 1, 3'd1, 8'h81, 0, 0, 8'h81, 0);
    add("shl",      0, 1, 3'd2, 8'h00, 0, 0, 8'h02, 0);
    add("shr",      0, 1, 3'd3, 8'h00, 1, 0, 8'h81, 0);
    add("shl_sin1", 0, 1, 3'd2, 8'h00, 0, 1, 8'h03, 0);
    // rotate
    add("load81b",  0, 1, 3'd1, 8'h81, 0, 0, 8'h81, 0);
    add("rol",      0, 1, 3'd4, 8'h00, 0, 0, 8'h03, 0);
    add("ror1",     0, 1, 3'd5, 8'h00, 0, 0, 8'h81, 0);
    add("ror2",     0, 1, 3'd5, 8'h00, 0, 0, 8'hC0, 0);
    // count wrap and TC
    add("loadFE",   0, 1, 3'd1, 8'hFE, 0, 0, 8'hFE, 0);
    add("upFE",     0, 1, 3'd6, 8'h00, 0, 0, 8'hFF, 0);
    add("upFF",     0, 1, 3'd6, 8'h00, 0, 0, 8'h00, 1);
    add("dn00",     0, 1, 3'd7, 8'h00, 0, 0, 8'hFF, 1);
    add("dnFF",     0, 1, 3'd7, 8'h00, 0, 0, 8'hFE, 0);
    add("upFE2",    0, 1, 3'd6, 8'h00, 0, 0, 8'hFF, 0);
    // enable low holds, TC suppressed
    for (int i = 0; i < 5; i++) add("en0", 0, 0, 3'd6, 8'h55, 1, 1, 8'hFF, 0);
    // reset priority
    add("rst_load", 1, 1, 3'd1, 8'h3C, 0, 0, 8'hA5, 0);
    add("loadFF",   0, 1, 3'd1, 8'hFF, 0, 0, 8'hFF, 0);
    add("rst_up",   1, 1, 3'd6, 8'h00, 0, 0, 8'hA5, 0);
    add("dnA5",     0, 1, 3'd7, 8'h00, 0, 0, 8'hA4, 0);
    add("load00",   0, 1, 3'd1, 8'h00, 0, 0, 8'h00, 0);
    add("up00",     0, 1, 3'd6, 8'h00, 0, 0, 8'h01, 0);
    add("shl_0",    0, 1, 3'd2, 8'h00, 0, 0, 8'h02, 0);

    tick();
    foreach (vecs[i]) begin
      drive8(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].d, vecs[i].sl, vecs[i].sr);
      #1;
      check({vecs[i].name, "_tc"}, 32'(tc8), 32'(vecs[i].etc));
      tick();
      check({vecs[i].name, "_q"}, 32'(q8), 32'(vecs[i].eq));
      check({vecs[i].name, "_soutl"}, 32'(soutl8), 32'(vecs[i].eq[7]));
      check({vecs[i].name, "_soutr"}, 32'(soutr8), 32'(vecs[i].eq[0]));
      model_q = vecs[i].eq;
    end

    // eight rotate-left steps return to the start value
    begin
      logic [7:0] start;
      drive8(0, 1, 3'd1, 8'hB4, 0, 0);
      tick();
      start = 8'hB4;
      check("rol8_load", 32'(q8), 32'(start));
      for (int i = 0; i < 8; i++) begin
        drive8(0, 1, 3'd4, 8'h00, 0, 0);
        tick();
      end
      check("rol8_back", 32'(q8), 32'(start));
      model_q = start;
    end

    // randomized run against the reference model
    for (int i = 0; i < 2000; i++) begin
      logic       r, e, sl, sr;
      logic [2:0] m;
      logic [7:0] d;
      r  = ($urandom_range(0, 39) == 0);
      e  = ($urandom_range(0, 9) != 0);
      m  = 3'($urandom_range(0, 7));
      sl = 1'($urandom_range(0, 1));
      sr = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: d = 8'hFF;
        1: d = 8'h00;
        default: d = 8'($urandom);
      endcase
      drive8(r, e, m, d, sl, sr);
      exp_q.push_back(ref_next(model_q, r, e, m, d, sl, sr));
      #1;
      check("rnd_tc", 32'(tc8), 32'(ref_tc(model_q, r, e, m)));
      tick();
      model_q = exp_q.pop_front();
      check("rnd_q", 32'(q8), 32'(model_q));
      check("rnd_sout", 32'({soutl8, soutr8}), 32'({model_q[7], model_q[0]}));
    end
    drive8(0, 0, 3'd0, 8'h00, 0, 0);

    // minimum width
    drive2(1, 1, 3'd6, 2'b00, 0, 0);
    tick();
    check("w2_rst", 32'(q2), 32'(2'b10));
    drive2(0, 1, 3'd4, 2'b00, 0, 0);
    tick();
    check("w2_rol", 32'(q2), 32'(2'b01));
    drive2(0, 1, 3'd3, 2'b00, 1, 0);
    tick();
    check("w2_shr", 32'(q2), 32'(2'b10));
    check("w2_sout", 32'({soutl2, soutr2}), 32'(2'b10));
    drive2(0, 1, 3'd1, 2'b11, 0, 0);
    tick();
    check("w2_load", 32'(q2), 32'(2'b11));
    drive2(0, 1, 3'd6, 2'b00, 0, 0);
    #1;
    check("w2_tc", 32'(tc2), 32'(1));
    tick();
    check("w2_wrap", 32'(q2), 32'(2'b00));
    check("w2_tc_after", 32'(tc2), 32'(0));
    drive2(0, 0, 3'd0, 2'b00, 0, 0);

    // cascade of two 4-bit counters
    cas_rst = 1'b1;
    lo_en   = 1'b1;
    tick();
    check("cas_rst", 32'({hi_q, lo_q}), 32'(8'h00));
    cas_rst = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 16) check("cas_16", 32'({hi_q, lo_q}), 32'(8'h10));
    end
    check("cas_300", 32'({hi_q, lo_q}), 32'(300 % 256));
    lo_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
